// File: rtl/imem_read_responder_if.sv
// imem_read_responder_if: fetch-side request/response and memory-side burst read bus
interface imem_read_responder_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] S_R_ADDR;
  logic                  S_R_ADDR_VALID;
  logic [31:0]           S_R_DATA;
  logic                  S_R_DATA_VALID;
  logic                  invalidate;
  logic [ADDR_WIDTH-1:0] M_R_ADDR;
  logic                  M_R_ADDR_VALID;
  logic                  M_R_ADDR_READY;
  logic [DATA_WIDTH-1:0] M_R_DATA;
  logic                  M_R_DATA_VALID;
  logic                  M_R_LAST;
  logic                  fill_error;
  modport slave (
    input  S_R_ADDR, S_R_ADDR_VALID, invalidate, M_R_ADDR_READY, M_R_DATA, M_R_DATA_VALID, M_R_LAST,
    output S_R_DATA, S_R_DATA_VALID, M_R_ADDR, M_R_ADDR_VALID, fill_error
  );
  modport master (
    output S_R_ADDR, S_R_ADDR_VALID, invalidate, M_R_ADDR_READY, M_R_DATA, M_R_DATA_VALID, M_R_LAST,
    input  S_R_DATA, S_R_DATA_VALID, M_R_ADDR, M_R_ADDR_VALID, fill_error
  );
endinterface

// File: rtl/imem_read_responder.sv
// imem_read_responder: single-line instruction buffer, zero-latency hits, burst refill on miss
module imem_read_responder #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int BUFFER_SIZE = 512
) (
  input  logic                clk,
  input  logic                reset,
  imem_read_responder_if.slave bus
);
  localparam int BEATS = BUFFER_SIZE / DATA_WIDTH;
  localparam int BW    = $clog2(BEATS);
  localparam int OFF   = $clog2(BUFFER_SIZE / 8);
  localparam int TW    = ADDR_WIDTH - OFF;
  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
  state_t                 state_q;
  logic [BUFFER_SIZE-1:0] line_q;
  logic [TW-1:0]          line_tag_q, fill_tag_q, tag;
  logic [OFF-3:0]         word;
  logic [BW-1:0]          beat_cnt_q;
  logic [ADDR_WIDTH-1:0]  m_addr_q;
  logic                   line_valid_q, fill_kill_q, m_addr_valid_q, fill_error_q;
  logic                   match, hit, last_beat;
  // address decode and hit detection; hits are answered in the same cycle
  always_comb begin
    tag       = bus.S_R_ADDR[ADDR_WIDTH-1:OFF];
    word      = bus.S_R_ADDR[OFF-1:2];
    match     = line_valid_q && line_tag_q == tag;
    hit       = state_q == IDLE && bus.S_R_ADDR_VALID && match && !bus.invalidate;
    last_beat = beat_cnt_q == BW'(BEATS - 1);
  end
  assign bus.S_R_DATA_VALID = hit;
  assign bus.S_R_DATA       = hit ? line_q[word*32 +: 32] : 32'd0;
  assign bus.M_R_ADDR       = m_addr_q;
  assign bus.M_R_ADDR_VALID = m_addr_valid_q;
  assign bus.fill_error     = fill_error_q;
  // refill FSM: request the line, collect beats in order, validate only a clean, unkilled burst
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      line_valid_q   <= 1'b0;
      fill_kill_q    <= 1'b0;
      beat_cnt_q     <= '0;
      m_addr_q       <= '0;
      m_addr_valid_q <= 1'b0;
      fill_error_q   <= 1'b0;
    end else begin
      fill_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.invalidate) line_valid_q <= 1'b0;
          else if (bus.S_R_ADDR_VALID && !match) begin
            fill_tag_q     <= tag;
            fill_kill_q    <= 1'b0;
            beat_cnt_q     <= '0;
            m_addr_q       <= {tag, {OFF{1'b0}}};
            m_addr_valid_q <= 1'b1;
            state_q        <= REQ;
          end
        end
        REQ: begin
          if (bus.invalidate) fill_kill_q <= 1'b1;
          if (bus.M_R_ADDR_READY) begin
            m_addr_valid_q <= 1'b0;
            state_q        <= FILL;
          end
        end
        FILL: begin
          if (bus.invalidate) fill_kill_q <= 1'b1;
          if (bus.M_R_DATA_VALID) begin
            line_q[beat_cnt_q*DATA_WIDTH +: DATA_WIDTH] <= bus.M_R_DATA;
            beat_cnt_q   <= beat_cnt_q + 1'b1;
            line_valid_q <= 1'b0;
            if (bus.M_R_LAST && last_beat) begin
              line_tag_q   <= fill_tag_q;
              line_valid_q <= !(fill_kill_q || bus.invalidate);
              state_q      <= IDLE;
            end else if (bus.M_R_LAST || last_beat) begin
              fill_error_q <= 1'b1;
              state_q      <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_read_responder.sv
// tb_imem_read_responder: directed refill, hit, invalidate, error and reset checks
module tb_imem_read_responder;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  imem_read_responder_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();
  imem_read_responder #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .BUFFER_SIZE(512)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // beat i of the line at base b carries words b/4+2i (low) and b/4+2i+1 (high)
  function automatic logic [63:0] beat_of(input logic [63:0] b, input int i);
    logic [31:0] w;
    w = 32'(b >> 2) + 32'(2 * i);
    return {w + 32'd1, w};
  endfunction
  task automatic hit(input logic [63:0] a);
    bus.S_R_ADDR = a;
    bus.S_R_ADDR_VALID = 1'b1;
    #1;
    chk("hit_valid", 64'(bus.S_R_DATA_VALID), 64'd1);
    chk("hit_data", 64'(bus.S_R_DATA), 64'(32'(a >> 2)));
    step();
  endtask
  task automatic do_fill(input logic [63:0] base, input int rdy_dly, input bit gaps,
                         input int last_at, input int inval_at, input int rst_at, input bit peek);
    int t;
    logic [63:0] save;
    t = 0;
    step();
    while (!bus.M_R_ADDR_VALID && t < 20) begin
      step();
      t++;
    end
    chk("req_valid", 64'(bus.M_R_ADDR_VALID), 64'd1);
    chk("req_addr", bus.M_R_ADDR, base);
    if (peek) begin
      save = bus.S_R_ADDR;
      bus.S_R_ADDR = 64'd0;
      #1;
      chk("no_resp_in_req", 64'(bus.S_R_DATA_VALID), 64'd0);
      bus.S_R_ADDR = save;
    end
    for (int k = 0; k < rdy_dly; k++) begin
      step();
      chk("req_held_addr", bus.M_R_ADDR, base);
      chk("req_held_valid", 64'(bus.M_R_ADDR_VALID), 64'd1);
    end
    bus.M_R_ADDR_READY = 1'b1;
    step();
    bus.M_R_ADDR_READY = 1'b0;
    chk("req_dropped", 64'(bus.M_R_ADDR_VALID), 64'd0);
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      bus.M_R_DATA = beat_of(base, i);
      bus.M_R_DATA_VALID = 1'b1;
      bus.M_R_LAST = (i == last_at);
      bus.invalidate = (i == inval_at);
      reset = (i == rst_at);
      step();
      bus.M_R_DATA_VALID = 1'b0;
      bus.M_R_LAST = 1'b0;
      bus.invalidate = 1'b0;
      reset = 1'b0;
      if (i == last_at || i == rst_at) break;
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1;
    bus.S_R_ADDR = '0;
    bus.S_R_ADDR_VALID = 1'b0;
    bus.invalidate = 1'b0;
    bus.M_R_ADDR_READY = 1'b0;
    bus.M_R_DATA = '0;
    bus.M_R_DATA_VALID = 1'b0;
    bus.M_R_LAST = 1'b0;
    step();
    step();
    chk("rst_sdv", 64'(bus.S_R_DATA_VALID), 64'd0);
    chk("rst_sdata", 64'(bus.S_R_DATA), 64'd0);
    chk("rst_maddr", bus.M_R_ADDR, 64'd0);
    chk("rst_mvalid", 64'(bus.M_R_ADDR_VALID), 64'd0);
    chk("rst_ferr", 64'(bus.fill_error), 64'd0);
    reset = 1'b0;
    bus.S_R_ADDR = 64'h0;
    bus.S_R_ADDR_VALID = 1'b1;
    #1;
    chk("cold_miss", 64'(bus.S_R_DATA_VALID), 64'd0);
    do_fill(64'h0, 1, 1'b0, 7, -1, -1, 1'b0);
    for (int a = 0; a < 64; a += 4) hit(64'(a));
    hit(64'h7);
    bus.S_R_ADDR = 64'h40;
    #1;
    chk("cross_miss", 64'(bus.S_R_DATA_VALID), 64'd0);
    do_fill(64'h40, 0, 1'b0, 7, -1, -1, 1'b1);
    hit(64'h40);
    hit(64'h7c);
    bus.S_R_ADDR = 64'h1000;
    do_fill(64'h1000, 5, 1'b1, 7, -1, -1, 1'b0);
    for (int a = 0; a < 64; a += 4) hit(64'h1000 + 64'(a));
    bus.S_R_ADDR = 64'h40;
    #1;
    chk("old_line_miss", 64'(bus.S_R_DATA_VALID), 64'd0);
    bus.S_R_ADDR_VALID = 1'b0;
    step();
    chk("no_fill_without_valid", 64'(bus.M_R_ADDR_VALID), 64'd0);
    bus.S_R_ADDR = 64'h1004;
    bus.S_R_ADDR_VALID = 1'b1;
    bus.invalidate = 1'b1;
    #1;
    chk("inval_blocks_hit", 64'(bus.S_R_DATA_VALID), 64'd0);
    step();
    bus.invalidate = 1'b0;
    #1;
    chk("inval_clears_line", 64'(bus.S_R_DATA_VALID), 64'd0);
    chk("inval_no_fill", 64'(bus.M_R_ADDR_VALID), 64'd0);
    bus.S_R_ADDR = 64'h80;
    do_fill(64'h80, 0, 1'b0, 7, 3, -1, 1'b0);
    #1;
    chk("killed_fill_no_hit", 64'(bus.S_R_DATA_VALID), 64'd0);
    do_fill(64'h80, 0, 1'b0, 7, -1, -1, 1'b0);
    hit(64'h84);
    bus.S_R_ADDR = 64'hc0;
    do_fill(64'hc0, 0, 1'b0, 5, -1, -1, 1'b0);
    chk("early_last_err", 64'(bus.fill_error), 64'd1);
    chk("early_last_no_hit", 64'(bus.S_R_DATA_VALID), 64'd0);
    step();
    chk("err_one_cycle", 64'(bus.fill_error), 64'd0);
    chk("refetch_req", 64'(bus.M_R_ADDR_VALID), 64'd1);
    do_fill(64'hc0, 0, 1'b0, 7, -1, -1, 1'b0);
    hit(64'hc8);
    bus.S_R_ADDR = 64'h100;
    do_fill(64'h100, 0, 1'b0, -1, -1, -1, 1'b0);
    chk("missing_last_err", 64'(bus.fill_error), 64'd1);
    chk("missing_last_no_hit", 64'(bus.S_R_DATA_VALID), 64'd0);
    do_fill(64'h100, 0, 1'b0, 7, -1, -1, 1'b0);
    hit(64'h13c);
    bus.S_R_ADDR = 64'h140;
    do_fill(64'h140, 0, 1'b0, 7, -1, 4, 1'b0);
    bus.S_R_ADDR_VALID = 1'b0;
    chk("rst_mid_mvalid", 64'(bus.M_R_ADDR_VALID), 64'd0);
    chk("rst_mid_ferr", 64'(bus.fill_error), 64'd0);
    for (int i = 5; i < 8; i++) begin
      bus.M_R_DATA = beat_of(64'h140, i);
      bus.M_R_DATA_VALID = 1'b1;
      bus.M_R_LAST = (i == 7);
      step();
      chk("drain_no_req", 64'(bus.M_R_ADDR_VALID), 64'd0);
      chk("drain_no_err", 64'(bus.fill_error), 64'd0);
    end
    bus.M_R_DATA_VALID = 1'b0;
    bus.M_R_LAST = 1'b0;
    bus.S_R_ADDR = 64'h100;
    bus.S_R_ADDR_VALID = 1'b1;
    #1;
    chk("rst_line_invalid", 64'(bus.S_R_DATA_VALID), 64'd0);
    do_fill(64'h100, 0, 1'b0, 7, -1, -1, 1'b0);
    hit(64'h100);
    hit(64'h118);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rst_idle_clears_line", 64'(bus.S_R_DATA_VALID), 64'd0);
    bus.S_R_ADDR_VALID = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imem_read_responder.md
Name: imem_read_responder

Overview:
- Responder end of the instruction-fetch read interface (S_R_ADDR / S_R_ADDR_VALID → S_R_DATA / S_R_DATA_VALID).
- Holds one 64-byte instruction line. Answers hits combinationally, in the same cycle, so the fetch stage advances pc every cycle on a hit.
- On a miss it fetches the line from the memory port as a burst of 64-bit beats, then serves from the filled line.

Parameters:
- ADDR_WIDTH, 64, byte-address width on both ports.
- DATA_WIDTH, 64, memory-port beat width. The instruction word is fixed at 32 bits.
- BUFFER_SIZE, 512, line size in bits (64 bytes). BEATS = BUFFER_SIZE/DATA_WIDTH = 8.

Ports:
- clk  input  1  clock; all state updates on the posedge.
- reset  input  1  synchronous, active-high reset.
- S_R_ADDR  input  ADDR_WIDTH  instruction byte address from fetch.
- S_R_ADDR_VALID  input  1  read request valid.
- S_R_DATA  output  32  instruction word.
- S_R_DATA_VALID  output  1  S_R_DATA is valid for the current S_R_ADDR.
- invalidate  input  1  drop the buffered line (fence.i / reload).
- M_R_ADDR  output  ADDR_WIDTH  line-aligned burst address.
- M_R_ADDR_VALID  output  1  burst request valid.
- M_R_ADDR_READY  input  1  memory accepts the request.
- M_R_DATA  input  DATA_WIDTH  burst beat data.
- M_R_DATA_VALID  input  1  beat valid.
- M_R_LAST  input  1  final beat of the burst.
- fill_error  output  1  one-cycle pulse: M_R_LAST came on the wrong beat.

Behaviour:
- Decode:
  - tag = S_R_ADDR[ADDR_WIDTH-1:6]
  - word = S_R_ADDR[5:2]
  - S_R_ADDR[1:0] ignored (treated as 0)
- State: line[511:0], line_tag, line_valid, fill_tag, fill_kill, beat_cnt[2:0], FSM {IDLE, REQ, FILL}.
- Reset: state=IDLE, line_valid=0, fill_kill=0, beat_cnt=0. All outputs 0: S_R_DATA_VALID=0, S_R_DATA=0, M_R_ADDR=0, M_R_ADDR_VALID=0, fill_error=0.
- Hit, combinational, 0-cycle latency:
  - Condition: state==IDLE && S_R_ADDR_VALID && line_valid && line_tag==tag && !invalidate.
  - Then S_R_DATA_VALID=1 and S_R_DATA=line[word*32 +: 32], little-endian (word 0 = bits 31:0).
  - Otherwise S_R_DATA_VALID=0 and S_R_DATA=0.
- IDLE:
  - invalidate=1: line_valid←0 next cycle; stay IDLE.
  - Else, S_R_ADDR_VALID && miss: fill_tag←tag, fill_kill←0, beat_cnt←0, go to REQ.
- REQ:
  - M_R_ADDR_VALID=1 and M_R_ADDR={fill_tag, 6'b0}, held stable until accepted.
  - M_R_ADDR_READY=1: go to FILL next cycle; M_R_ADDR_VALID drops.
- FILL:
  - Each cycle with M_R_DATA_VALID: line[beat_cnt*64 +: 64]←M_R_DATA; beat_cnt++.
  - M_R_LAST && beat_cnt==7: line_tag←fill_tag; line_valid←!fill_kill; go to IDLE. The first hit is possible the cycle after LAST.
  - M_R_LAST && beat_cnt!=7: fill_error=1 for one cycle, line_valid←0, go to IDLE.
  - beat_cnt==7 && beat valid && !M_R_LAST: same as the wrong-beat LAST case, with fill_error=1.
- line_valid is 0 from the first FILL beat until completion, because line contents are being overwritten.
- No responses in REQ or FILL; S_R_DATA_VALID=0 there even if the address matches the old line.
- S_R_ADDR changing during REQ/FILL: the fill still completes for fill_tag. Back in IDLE, the new address is compared and misses again if needed.
- invalidate during REQ/FILL: fill_kill←1. The burst completes normally, then line_valid stays 0.
- S_R_ADDR_VALID=0: no response and no new fill started.
- Reset mid-burst: FSM returns to IDLE and line_valid=0. Remaining beats from the aborted burst that arrive in IDLE are ignored; the memory side must drain them.
- Address arithmetic: wraps modulo 2^ADDR_WIDTH. A 32-bit word never crosses a line.

Test Plan:
- Cold miss: reset, then S_R_ADDR=0x0 valid. Require M_R_ADDR_VALID=1 with M_R_ADDR=0x0 the next cycle. Ready on cycle 3, then 8 beats with beat i = {32'h(2i+1), 32'h(2i)}. One cycle after LAST: S_R_DATA=0x0, VALID=1, same cycle.
- Sequential hits: after the fill, step addr 0x0, 0x4 … 0x3C one per cycle. Require VALID=1 every cycle and S_R_DATA = addr/4.
- Line crossing: addr=0x40 after the above. Require VALID=0, M_R_ADDR=0x40; then hit at 0x40 after the fill.
- Backpressure and gaps: M_R_ADDR_READY held low 5 cycles, then random M_R_DATA_VALID gaps. Require M_R_ADDR stable while unaccepted, and beats land in order.
- Invalidate mid-fill: invalidate pulsed on beat 3 of the fill for 0x80. Require VALID=0 at 0x80 after completion, then a new burst to 0x80.
- Errors and reset: M_R_LAST on beat 5 → fill_error pulses 1 cycle and a refetch follows. reset on beat 4 → M_R_ADDR_VALID=0, VALID=0, line_valid=0.
